// File: rtl/jelly3_jfive_instruction_decode.sv
// RV32I instruction decoder for the jfive multithreaded pipeline.
// Latency: 1 cycle from s_valid&&s_ready to m_valid (main output register plus one skid entry).
// Backpressure: s_ready = !skid_valid, registered only; a taken branch kills matching-id beats.
//
// Ports:
//   reset/clk/cke              : synchronous active-high reset, rising-edge clock, clock enable
//   branch_en/_id/_pc          : taken-branch notification; branch_pc is not used here
//   s_id/s_pc/s_inst/s_valid   : fetch-side input stream, s_ready back to fetch
//   m_*                        : decoded fields, m_valid/m_ready handshake to execute
//
// Optional feature: define JELLY3_JFIVE_DECODE_ILLEGAL_EN to compile illegal-opcode
// detection into m_illegal; otherwise m_illegal is tied to 0.
//
// m_op is an enumerated class code: 0 alu, 1 alu_imm, 2 load, 3 store, 4 branch,
// 5 jal, 6 jalr, 7 lui, 8 auipc, 9 system. Unknown opcodes decode as system
// (no register enables, zero immediate).

module jelly3_jfive_instruction_decode #(
  parameter int THREADS   = 4,
  parameter int ID_BITS   = THREADS > 1 ? $clog2(THREADS) : 1,
  parameter int PC_BITS   = 32,
  parameter int INST_BITS = 32
) (
  input  logic                 reset,
  input  logic                 clk,
  input  logic                 cke,

  input  logic                 branch_en,
  input  logic [ID_BITS-1:0]   branch_id,
  input  logic [PC_BITS-1:0]   branch_pc,

  input  logic [ID_BITS-1:0]   s_id,
  input  logic [PC_BITS-1:0]   s_pc,
  input  logic [INST_BITS-1:0] s_inst,
  input  logic                 s_valid,
  output logic                 s_ready,

  output logic [ID_BITS-1:0]   m_id,
  output logic [PC_BITS-1:0]   m_pc,
  output logic [INST_BITS-1:0] m_inst,
  output logic [4:0]           m_rd_idx,
  output logic                 m_rd_en,
  output logic [4:0]           m_rs1_idx,
  output logic                 m_rs1_en,
  output logic [4:0]           m_rs2_idx,
  output logic                 m_rs2_en,
  output logic [2:0]           m_funct3,
  output logic [6:0]           m_funct7,
  output logic [31:0]          m_imm,
  output logic [3:0]           m_op,
  output logic                 m_illegal,
  output logic                 m_valid,
  input  logic                 m_ready
);

  typedef logic [ID_BITS-1:0] id_t;
  typedef logic [PC_BITS-1:0] pc_t;

  localparam logic [3:0] OP_ALU     = 4'd0;
  localparam logic [3:0] OP_ALU_IMM = 4'd1;
  localparam logic [3:0] OP_LOAD    = 4'd2;
  localparam logic [3:0] OP_STORE   = 4'd3;
  localparam logic [3:0] OP_BRANCH  = 4'd4;
  localparam logic [3:0] OP_JAL     = 4'd5;
  localparam logic [3:0] OP_JALR    = 4'd6;
  localparam logic [3:0] OP_LUI     = 4'd7;
  localparam logic [3:0] OP_AUIPC   = 4'd8;
  localparam logic [3:0] OP_SYSTEM  = 4'd9;

  typedef struct packed {
    id_t                  id;
    pc_t                  pc;
    logic [INST_BITS-1:0] inst;
    logic [4:0]           rd_idx;
    logic                 rd_en;
    logic [4:0]           rs1_idx;
    logic                 rs1_en;
    logic [4:0]           rs2_idx;
    logic                 rs2_en;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [31:0]          imm;
    logic [3:0]           op;
    logic                 illegal;
  } dec_t;

  // branch_pc is carried only so this port list mirrors the fetch stage
  logic unused_branch_pc;
  assign unused_branch_pc = ^branch_pc;

  // ---------------- combinational decode of the incoming beat ----------------
  dec_t dec;
  logic rd_write;
  logic known_op;

  always_comb begin
    dec         = '0;
    rd_write    = 1'b0;
    known_op    = 1'b1;
    dec.id      = s_id;
    dec.pc      = s_pc;
    dec.inst    = s_inst;
    dec.rd_idx  = s_inst[11:7];
    dec.rs1_idx = s_inst[19:15];
    dec.rs2_idx = s_inst[24:20];
    dec.funct3  = s_inst[14:12];
    dec.funct7  = s_inst[31:25];
    case (s_inst[6:0])
      7'h33: begin dec.op = OP_ALU;     rd_write = 1'b1; dec.rs1_en = 1'b1; dec.rs2_en = 1'b1; end
      7'h13: begin dec.op = OP_ALU_IMM; rd_write = 1'b1; dec.rs1_en = 1'b1;
                   dec.imm = {{20{s_inst[31]}}, s_inst[31:20]}; end
      7'h03: begin dec.op = OP_LOAD;    rd_write = 1'b1; dec.rs1_en = 1'b1;
                   dec.imm = {{20{s_inst[31]}}, s_inst[31:20]}; end
      7'h23: begin dec.op = OP_STORE;   dec.rs1_en = 1'b1; dec.rs2_en = 1'b1;
                   dec.imm = {{20{s_inst[31]}}, s_inst[31:25], s_inst[11:7]}; end
      7'h63: begin dec.op = OP_BRANCH;  dec.rs1_en = 1'b1; dec.rs2_en = 1'b1;
                   dec.imm = {{20{s_inst[31]}}, s_inst[7], s_inst[30:25], s_inst[11:8], 1'b0}; end
      7'h6F: begin dec.op = OP_JAL;     rd_write = 1'b1;
                   dec.imm = {{12{s_inst[31]}}, s_inst[19:12], s_inst[20], s_inst[30:21], 1'b0}; end
      7'h67: begin dec.op = OP_JALR;    rd_write = 1'b1; dec.rs1_en = 1'b1;
                   dec.imm = {{20{s_inst[31]}}, s_inst[31:20]}; end
      7'h37: begin dec.op = OP_LUI;     rd_write = 1'b1; dec.imm = {s_inst[31:12], 12'h000}; end
      7'h17: begin dec.op = OP_AUIPC;   rd_write = 1'b1; dec.imm = {s_inst[31:12], 12'h000}; end
      7'h73: begin dec.op = OP_SYSTEM; end
      default: begin dec.op = OP_SYSTEM; known_op = 1'b0; end
    endcase
    // writes to x0 are architecturally discarded, so never request them
    dec.rd_en = rd_write && (s_inst[11:7] != 5'd0);
`ifdef JELLY3_JFIVE_DECODE_ILLEGAL_EN
    dec.illegal = !known_op || (s_inst[1:0] != 2'b11);
`else
    dec.illegal = 1'b0;
`endif
  end

  // ---------------- output register + skid ----------------
  dec_t out_q, out_d, skid_q, skid_d;
  logic out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic in_drop;

  assign s_ready = !skid_vld_q;
  assign in_drop = branch_en && (s_id == branch_id);

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    // pop first; skid moves forward in the same cycle
    if (out_vld_q && m_ready) begin
      out_d      = skid_q;
      out_vld_d  = skid_vld_q;
      skid_vld_d = 1'b0;
    end
    // flush acts on the post-pop contents
    if (branch_en) begin
      if (out_vld_d && out_d.id == branch_id) out_vld_d = 1'b0;
      if (skid_vld_d && skid_d.id == branch_id) skid_vld_d = 1'b0;
    end
    // a flushed output must not leave a surviving skid entry stranded behind it
    if (!out_vld_d && skid_vld_d) begin
      out_d      = skid_d;
      out_vld_d  = 1'b1;
      skid_vld_d = 1'b0;
    end
    if (s_valid && s_ready && !in_drop) begin
      if (!out_vld_d) begin
        out_d     = dec;
        out_vld_d = 1'b1;
      end else begin
        skid_d     = dec;
        skid_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (cke) begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  // payload needs no reset; it is qualified by the valid flags
  always_ff @(posedge clk) begin
    if (cke) begin
      out_q  <= out_d;
      skid_q <= skid_d;
    end
  end

  assign m_valid   = out_vld_q;
  assign m_id      = out_q.id;
  assign m_pc      = out_q.pc;
  assign m_inst    = out_q.inst;
  assign m_rd_idx  = out_q.rd_idx;
  assign m_rd_en   = out_q.rd_en;
  assign m_rs1_idx = out_q.rs1_idx;
  assign m_rs1_en  = out_q.rs1_en;
  assign m_rs2_idx = out_q.rs2_idx;
  assign m_rs2_en  = out_q.rs2_en;
  assign m_funct3  = out_q.funct3;
  assign m_funct7  = out_q.funct7;
  assign m_imm     = out_q.imm;
  assign m_op      = out_q.op;
  assign m_illegal = out_q.illegal;

endmodule
